// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port framebuffer RAM between VGA scanout and a single
//   writer. The 320x240 framebuffer is pixel- and line-doubled onto 640x480
//   timing, so scanout needs a RAM read only on even active pixels. Every
//   other cycle, and every blanking cycle, is offered to the writer.
//   Pixel data and sync are delay-matched (2 cycles) for the DAC stage.
// Optional build macro:
//   FB_WR_COUNT_EN - adds the wr_count port, which reports the number of
//                    accepted in-range writes in the last full frame.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int FB_W     = H_ACTIVE / 2,
  parameter int FB_H     = V_ACTIVE / 2,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 12
) (
  input  logic              clk_pix,
  input  logic              resetn,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              de,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_rgb,
  output logic              pix_de,
  output logic              pix_hsync,
  output logic              pix_vsync,
`ifdef FB_WR_COUNT_EN
  output logic [15:0]       wr_count,
`endif
  output logic              vblank_start
);

  localparam int FB_WORDS = FB_W * FB_H;

  logic              ready_q;
  logic              scan_slot;
  logic              in_range;
  logic              wr_hs;
  logic              wr_acc;
  logic [ADDR_W-1:0] row_a;
  logic [ADDR_W-1:0] col_a;
  logic [ADDR_W-1:0] scan_addr;

  logic              vld_p0;
  logic              de_p0;
  logic              hs_p0;
  logic              vs_p0;
  logic              de_p1;
  logic              hs_p1;
  logic              vs_p1;
  logic [DATA_W-1:0] rgb_p1;
  logic              vblank_q;

  // Gating with resetn keeps the RAM strobe low for the whole reset interval,
  // even though the timing generator may still be showing active video.
  assign scan_slot = resetn & de & ~hcount[0];

  // Row * 320 as (row << 8) + (row << 6); line doubling falls out of dropping vcount[0].
  assign row_a     = ADDR_W'(vcount[9:1]);
  assign col_a     = ADDR_W'(hcount[9:1]);
  assign scan_addr = (row_a << 8) + (row_a << 6) + col_a;

  assign in_range  = ({1'b0, wr_addr} < (ADDR_W + 1)'(FB_WORDS));
  assign wr_ready  = ready_q & ~scan_slot;
  assign wr_hs     = wr_valid & wr_ready;
  assign wr_acc    = wr_hs & in_range;

  // RAM port mux: scanout read wins, otherwise an in-range accepted write, otherwise idle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (scan_slot) begin
      ram_en   = 1'b1;
      ram_addr = scan_addr;
    end else if (wr_acc) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
    end
  end

  // Writer slot enable: opens on the first clock edge after reset release.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  // ---- stage p0: read issued last cycle, timing delayed by one ----
  // Track which cycle has read data returning and delay the timing by one.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      vld_p0 <= 1'b0;
      de_p0  <= 1'b0;
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
    end else begin
      vld_p0 <= scan_slot;
      de_p0  <= de;
      hs_p0  <= hsync;
      vs_p0  <= vsync;
    end
  end

  // ---- stage p1: pixel and timing delayed by two ----
  // Capture returning RAM word and hold it across both doubled pixels; blank outside de.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      de_p1  <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      rgb_p1 <= '0;
    end else begin
      de_p1 <= de_p0;
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;
      if (!de_p0)      rgb_p1 <= '0;
      else if (vld_p0) rgb_p1 <= ram_rdata;
    end
  end

  // One-cycle pulse after the first blanking line starts.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) vblank_q <= 1'b0;
    else         vblank_q <= (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
  end

  assign pix_rgb      = rgb_p1;
  assign pix_de       = de_p1;
  assign pix_hsync    = hs_p1;
  assign pix_vsync    = vs_p1;
  assign vblank_start = vblank_q;

`ifdef FB_WR_COUNT_EN
  logic [15:0] wr_cnt_q;
  logic [15:0] wr_count_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Per-frame write counter; snapshot and restart on the vblank pulse, which
  // lets a write in that same cycle count as the first of the new frame.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      wr_cnt_q   <= '0;
      wr_count_q <= '0;
    end else if (vblank_q) begin
      wr_count_q <= wr_cnt_q;
      wr_cnt_q   <= wr_acc ? 16'd1 : 16'd0;
    end else if (wr_acc) begin
      wr_cnt_q <= sat_inc16(wr_cnt_q);
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: a pixel-position model predicts all
// outputs every cycle; literal expectations pin key addresses and pixels.
module tb_vga_fb_arbiter;

  logic        clk_pix = 1'b0;
  logic        resetn;
  logic [9:0]  hcount, vcount;
  logic        hsync, vsync, de;
  logic        wr_valid;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready, ram_en, ram_we;
  logic [16:0] ram_addr;
  logic [11:0] ram_wdata, ram_rdata;
  logic [11:0] pix_rgb;
  logic        pix_de, pix_hsync, pix_vsync, vblank_start;
`ifdef FB_WR_COUNT_EN
  logic [15:0] wr_count;
`endif

  int checks = 0;
  int errors = 0;
  int vb_seen = 0;
  logic chk_en = 1'b0;

  vga_fb_arbiter dut (
    .clk_pix(clk_pix), .resetn(resetn), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .de(de), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pix_rgb(pix_rgb),
    .pix_de(pix_de), .pix_hsync(pix_hsync), .pix_vsync(pix_vsync),
`ifdef FB_WR_COUNT_EN
    .wr_count(wr_count),
`endif
    .vblank_start(vblank_start)
  );

  always #5 clk_pix = ~clk_pix;

  // RAM: a read returns its own address bits next cycle; anything else returns junk.
  always @(posedge clk_pix) ram_rdata <= (ram_en && !ram_we) ? ram_addr[11:0] : 12'hBAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Framebuffer word shown at screen position (h, v), low 12 bits.
  function automatic logic [11:0] word(input int v, input int h);
    int a;
    a = (v / 2) * 320 + h / 2;
    return a[11:0];
  endfunction

  // ---------------- model ----------------
  logic [9:0] h_h [2];
  logic [9:0] v_h [2];
  logic       de_h [2];
  logic       hs_h [2];
  logic       vs_h [2];
  logic       ready_m;
  logic       vb_m;
  logic [15:0] cnt_m, wrc_m;

  function automatic logic acc_now();
    return wr_valid && ready_m && !(de && !hcount[0]) && (wr_addr < 17'd76800);
  endfunction

  always @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        h_h[i] <= '0; v_h[i] <= '0; de_h[i] <= 1'b0; hs_h[i] <= 1'b0; vs_h[i] <= 1'b0;
      end
      ready_m <= 1'b0;
      vb_m    <= 1'b0;
      cnt_m   <= '0;
      wrc_m   <= '0;
    end else begin
      ready_m <= 1'b1;
      h_h[1] <= h_h[0]; h_h[0] <= hcount;
      v_h[1] <= v_h[0]; v_h[0] <= vcount;
      de_h[1] <= de_h[0]; de_h[0] <= de;
      hs_h[1] <= hs_h[0]; hs_h[0] <= hsync;
      vs_h[1] <= vs_h[0]; vs_h[0] <= vsync;
      vb_m <= (vcount == 10'd480) && (hcount == 10'd0);
      if (vb_m) begin
        wrc_m <= cnt_m;
        cnt_m <= acc_now() ? 16'd1 : 16'd0;
      end else if (acc_now() && cnt_m != 16'hFFFF) begin
        cnt_m <= cnt_m + 16'd1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_pix) begin
    if (chk_en) begin
      logic scan, wrr, wacc;
      logic [16:0] eaddr;
      int sa;
      scan = resetn && de && !hcount[0];
      wrr  = ready_m && !scan;
      wacc = wr_valid && wrr && (wr_addr < 17'd76800);
      sa   = (int'(vcount) / 2) * 320 + int'(hcount) / 2;
      eaddr = scan ? sa[16:0] : (wacc ? wr_addr : 17'd0);
      chk("wr_ready", wr_ready, wrr);
      chk("ram_en", ram_en, scan || wacc);
      chk("ram_we", ram_we, wacc);
      chk("ram_addr", ram_addr, eaddr);
      if (wacc) chk("ram_wdata", ram_wdata, wr_data);
      chk("pix_de", pix_de, de_h[1]);
      chk("pix_hsync", pix_hsync, hs_h[1]);
      chk("pix_vsync", pix_vsync, vs_h[1]);
      chk("pix_rgb", pix_rgb, de_h[1] ? word(int'(v_h[1]), int'(h_h[1])) : 12'd0);
      chk("vblank_start", vblank_start, vb_m);
`ifdef FB_WR_COUNT_EN
      chk("wr_count", wr_count, wrc_m);
`endif
      if (vblank_start) vb_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int h, input int v, input logic d, input logic hs, input logic vs,
                       input logic wv, input logic [16:0] wa, input logic [11:0] wd);
    @(posedge clk_pix);
    #1;
    hcount = 10'(h); vcount = 10'(v); de = d; hsync = hs; vsync = vs;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    @(negedge clk_pix);
  endtask

  task automatic run_line(input int v, input int h0, input int n, input logic wv);
    for (int i = 0; i < n; i++) begin
      int h;
      h = h0 + i;
      drive(h, v, (h < 640) && (v < 480), (h >= 656) && (h < 752), (v >= 490) && (v < 492),
            wv, 17'(2000 + h), 12'(h));
    end
  endtask

  initial begin
    resetn = 1'b1;
    hcount = 10'd700; vcount = 10'd500; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 12'h0A5;
    #2 resetn = 1'b0;
    #1 chk_en = 1'b1;

    // Reset state and release
    repeat (3) @(negedge clk_pix);
    chk("rst wr_ready", wr_ready, 1'b0);
    chk("rst ram_en", ram_en, 1'b0);
    chk("rst pix_de", pix_de, 1'b0);
    chk("rst vblank", vblank_start, 1'b0);
    #1 resetn = 1'b1;
    #1 chk("wr_ready before edge", wr_ready, 1'b0);
    drive(700, 500, 0, 0, 0, 1, 17'd5, 12'h0A5);
    chk("wr_ready after edge", wr_ready, 1'b1);
    chk("first write en", ram_en, 1'b1);
    chk("first write we", ram_we, 1'b1);
    chk("first write addr", ram_addr, 17'd5);
    run_line(500, 701, 4, 1'b1);

    // Line 0: scan read addresses and writer interleave
    drive(0, 0, 1, 0, 0, 1, 17'd900, 12'h123);
    chk("scan h0 we", ram_we, 1'b0);
    chk("scan h0 addr", ram_addr, 17'd0);
    chk("scan h0 wr_ready", wr_ready, 1'b0);
    drive(1, 0, 1, 0, 0, 1, 17'd901, 12'h124);
    chk("odd h1 wr_ready", wr_ready, 1'b1);
    chk("odd h1 write addr", ram_addr, 17'd901);
    drive(2, 0, 1, 0, 0, 1, 17'd902, 12'h125);
    chk("scan h2 addr", ram_addr, 17'd1);
    run_line(0, 3, 13, 1'b1);
    run_line(0, 640, 20, 1'b1);

    // Line 1 repeats row 0
    run_line(1, 0, 2, 1'b1);
    drive(2, 1, 1, 0, 0, 1, 17'd3000, 12'h0);
    chk("line1 h2 addr", ram_addr, 17'd1);
    run_line(1, 3, 13, 1'b0);
    run_line(1, 640, 8, 1'b0);

    // Line 2 (row 1) pixel data, then reset in mid-line
    run_line(2, 0, 4, 1'b1);
    drive(4, 2, 1, 0, 0, 1, 17'd2004, 12'h4);
    chk("row1 pix h2", pix_rgb, 12'd321);
    chk("row1 pix_de", pix_de, 1'b1);
    run_line(2, 5, 1, 1'b1);
    drive(6, 2, 1, 0, 0, 1, 17'd2006, 12'h6);
    #1 resetn = 1'b0;
    #1;
    chk("async rst ram_en", ram_en, 1'b0);
    chk("async rst pix_de", pix_de, 1'b0);
    chk("async rst pix_rgb", pix_rgb, 12'd0);
    chk("async rst wr_ready", wr_ready, 1'b0);
    run_line(2, 7, 2, 1'b1);
    #1 resetn = 1'b1;
    run_line(2, 9, 1, 1'b1);
    drive(10, 2, 1, 0, 0, 1, 17'd2010, 12'ha);
    chk("refill pix h8", pix_rgb, 12'd324);
    drive(11, 2, 1, 0, 0, 1, 17'd2011, 12'hb);
    chk("refill pix h9", pix_rgb, 12'd324);
    run_line(2, 12, 4, 1'b1);
    run_line(2, 640, 6, 1'b1);

    // Last visible line, bottom-right corner
    run_line(479, 630, 8, 1'b1);
    drive(638, 479, 1, 0, 0, 1, 17'd0, 12'h0);
    chk("corner addr", ram_addr, 17'd76799);
    run_line(479, 639, 1, 1'b1);
    drive(640, 479, 0, 0, 0, 1, 17'd2640, 12'h0);
    chk("corner pix", pix_rgb, 12'hBFF);
    run_line(479, 641, 10, 1'b1);
    drive(660, 479, 0, 1, 0, 1, 17'd76800, 12'h555);
    chk("oor wr_ready", wr_ready, 1'b1);
    chk("oor ram_en", ram_en, 1'b0);
    drive(661, 479, 0, 1, 0, 1, 17'd76799, 12'h666);
    chk("last addr write en", ram_en, 1'b1);
    chk("last addr wdata", ram_wdata, 12'h666);

    // First vblank, then 100 counted writes, then second vblank
    drive(0, 480, 0, 0, 0, 0, 17'd0, 12'h0);
    chk("vblank not yet", vblank_start, 1'b0);
    drive(1, 480, 0, 0, 0, 1, 17'd7, 12'h7);
    chk("vblank pulse", vblank_start, 1'b1);
    for (int i = 0; i < 99; i++) begin
      drive(3 + i, 481, 0, 0, 0, 1, 17'(i), 12'(i));
      if (i == 0) chk("vblank one cycle", vblank_start, 1'b0);
    end
    for (int i = 0; i < 3; i++) drive(110 + i, 481, 0, 0, 0, 1, 17'(76800 + i), 12'h0);
    drive(0, 480, 0, 0, 0, 0, 17'd0, 12'h0);
    drive(1, 480, 0, 0, 0, 0, 17'd0, 12'h0);
    drive(2, 480, 0, 0, 0, 0, 17'd0, 12'h0);
`ifdef FB_WR_COUNT_EN
    chk("wr_count frame", wr_count, 16'd100);
`endif
    run_line(481, 10, 4, 1'b0);
    chk("vblank pulses", vb_seen, 2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
